digest_table: RTL and testbench

DIGEST_TABLE -- requirements
Module: digest_table

---
 rtl/digest_table.sv | 159 +++++++++++++++
 tb/tb_digest_table.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/digest_table.sv
// Digest table: word-serial loading into a small table of digests, with a manual
// or auto-scanning registered read port and a registered lowest-index match port.
module digest_table #(
  parameter int DIGEST_W = 128,
  parameter int ENTRIES  = 16,
  parameter int IDX_W    = 4,
  parameter int LOAD_W   = 32,
  parameter int DWELL_W  = 24
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                clear,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [IDX_W-1:0]    load_idx,
  input  logic [LOAD_W-1:0]   load_word,
  input  logic                mode,
  input  logic [IDX_W-1:0]    selector,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [DIGEST_W-1:0] dataOut,
  output logic                dataOut_valid,
  output logic [IDX_W-1:0]    dataOut_idx,
  input  logic                cand_valid,
  input  logic [DIGEST_W-1:0] cand,
  output logic                hit_valid,
  output logic                hit,
  output logic [IDX_W-1:0]    hit_idx
);

  localparam int WORDS = DIGEST_W / LOAD_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W:0]   ENTRIES_L = (IDX_W+1)'(ENTRIES);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  logic [DIGEST_W-1:0] asm_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [IDX_W-1:0]    idx_cap_r;
  logic [DIGEST_W-1:0] entries_r [ENTRIES];
  logic [ENTRIES-1:0]  valid_r;
  logic [IDX_W-1:0]    scan_idx_r;
  logic [DWELL_W-1:0]  dwell_cnt_r;
  logic [DIGEST_W-1:0] data_out_r;
  logic                data_out_valid_r;
  logic [IDX_W-1:0]    data_out_idx_r;
  logic                hit_valid_r;
  logic                hit_r;
  logic [IDX_W-1:0]    hit_idx_r;

  logic                accept_s;
  logic [IDX_W-1:0]    tgt_s;
  logic                commit_s;
  logic [DIGEST_W-1:0] assembled_s;
  logic [IDX_W-1:0]    read_idx_s;
  logic                read_ok_s;
  logic [DWELL_W-1:0]  dwell_eff_s;
  logic [ENTRIES-1:0]  match_vec_s;
  logic [IDX_W-1:0]    match_idx_s;

  assign load_ready  = ~clear;
  assign accept_s    = load_valid & ~clear;
  assign tgt_s       = (cnt_r == '0) ? load_idx : idx_cap_r;
  assign commit_s    = accept_s && (cnt_r == LAST_WORD) && ({1'b0, tgt_s} < ENTRIES_L);
  assign read_idx_s  = mode ? scan_idx_r : selector;
  assign read_ok_s   = ({1'b0, read_idx_s} < ENTRIES_L);
  assign dwell_eff_s = (dwell == '0) ? DWELL_W'(1) : dwell;

  generate
    if (WORDS > 1) begin : g_shift
      assign assembled_s = {asm_r[DIGEST_W-LOAD_W-1:0], load_word};
    end else begin : g_single
      assign assembled_s = load_word;
    end
  endgenerate

  // Word assembly and word counter; a clear drops any partial digest.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      asm_r     <= '0;
      cnt_r     <= '0;
      idx_cap_r <= '0;
    end else if (clear) begin
      asm_r <= '0;
      cnt_r <= '0;
    end else if (load_valid) begin
      asm_r     <= assembled_s;
      idx_cap_r <= tgt_s;
      cnt_r     <= (cnt_r == LAST_WORD) ? '0 : cnt_r + CNT_W'(1);
    end
  end

  // Table storage: contents survive clear, only the valid bits drop.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) entries_r[i] <= '0;
      valid_r <= '0;
    end else begin
      if (commit_s) entries_r[tgt_s] <= assembled_s;
      if (clear) valid_r <= '0;
      else if (commit_s) valid_r[tgt_s] <= 1'b1;
    end
  end

  // Scan position; held at zero in manual mode so every entry into scan starts fresh.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      scan_idx_r  <= '0;
      dwell_cnt_r <= '0;
    end else if (!mode) begin
      scan_idx_r  <= '0;
      dwell_cnt_r <= '0;
    end else if (dwell_cnt_r >= dwell_eff_s - DWELL_W'(1)) begin
      dwell_cnt_r <= '0;
      scan_idx_r  <= ({1'b0, scan_idx_r} == ENTRIES_L - (IDX_W+1)'(1)) ? '0
                                                                     : scan_idx_r + IDX_W'(1);
    end else begin
      dwell_cnt_r <= dwell_cnt_r + DWELL_W'(1);
    end
  end

  // Lowest valid matching entry for the current candidate.
  always_comb begin
    match_vec_s = '0;
    match_idx_s = '0;
    for (int i = 0; i < ENTRIES; i++) match_vec_s[i] = valid_r[i] && (entries_r[i] == cand);
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match_vec_s[i]) match_idx_s = IDX_W'(i);
      else                match_idx_s = match_idx_s;
    end
  end

  // Registered read and match responses, both from pre-commit state.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      data_out_r       <= '0;
      data_out_valid_r <= 1'b0;
      data_out_idx_r   <= '0;
      hit_valid_r      <= 1'b0;
      hit_r            <= 1'b0;
      hit_idx_r        <= '0;
    end else begin
      data_out_r       <= read_ok_s ? entries_r[read_idx_s] : '0;
      data_out_valid_r <= read_ok_s ? valid_r[read_idx_s] : 1'b0;
      data_out_idx_r   <= read_idx_s;
      hit_valid_r      <= cand_valid;
      if (cand_valid) begin
        hit_r     <= |match_vec_s;
        hit_idx_r <= match_idx_s;
      end
    end
  end

  assign dataOut       = data_out_r;
  assign dataOut_valid = data_out_valid_r;
  assign dataOut_idx   = data_out_idx_r;
  assign hit_valid     = hit_valid_r;
  assign hit           = hit_r;
  assign hit_idx       = hit_idx_r;

endmodule

// File: tb/tb_digest_table.sv
// Bench for digest_table: an abstract table model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_digest_table;
  localparam int E = 16;

  logic         CLK = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [3:0]   load_idx = 4'd0;
  logic [31:0]  load_word = 32'd0;
  logic         mode = 1'b0;
  logic [3:0]   selector = 4'd0;
  logic [23:0]  dwell = 24'd0;
  logic [127:0] dataOut;
  logic         dataOut_valid;
  logic [3:0]   dataOut_idx;
  logic         cand_valid = 1'b0;
  logic [127:0] cand = 128'd0;
  logic         hit_valid;
  logic         hit;
  logic [3:0]   hit_idx;

  int total = 0;
  int bad = 0;
  bit run = 1'b0;

  digest_table dut (
    .CLK(CLK), .reset(reset), .clear(clear),
    .load_valid(load_valid), .load_ready(load_ready), .load_idx(load_idx), .load_word(load_word),
    .mode(mode), .selector(selector), .dwell(dwell),
    .dataOut(dataOut), .dataOut_valid(dataOut_valid), .dataOut_idx(dataOut_idx),
    .cand_valid(cand_valid), .cand(cand),
    .hit_valid(hit_valid), .hit(hit), .hit_idx(hit_idx)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model state: table contents, valid flags, words collected so far, scan age.
  logic [127:0] m_ent [E];
  logic [E-1:0] m_val;
  logic [31:0]  wbuf [4];
  int           wn = 0;
  int           cap = 0;
  int           scan_k = 0;
  logic [127:0] exp_do = '0;
  logic         exp_dov = 1'b0;
  logic [3:0]   exp_doi = 4'd0;
  logic         exp_hv = 1'b0;
  logic         exp_hit = 1'b0;
  logic [3:0]   exp_hidx = 4'd0;

  always @(posedge CLK) begin : model
    int r;
    int si;
    int fi;
    int c;
    bit found;
    if (reset) begin
      for (int i = 0; i < E; i++) m_ent[i] <= '0;
      m_val <= '0;
      wn <= 0; cap <= 0; scan_k <= 0;
      exp_do <= '0; exp_dov <= 1'b0; exp_doi <= 4'd0;
      exp_hv <= 1'b0; exp_hit <= 1'b0; exp_hidx <= 4'd0;
    end else begin
      si = (scan_k / ((dwell == 24'd0) ? 1 : int'(dwell))) % E;
      r  = mode ? si : int'(selector);
      exp_doi <= r[3:0];
      exp_do  <= (r < E) ? m_ent[r] : 128'd0;
      exp_dov <= (r < E) ? m_val[r] : 1'b0;
      scan_k  <= mode ? scan_k + 1 : 0;
      exp_hv  <= cand_valid;
      if (cand_valid) begin
        found = 1'b0; fi = 0;
        for (int i = 0; i < E; i++)
          if (!found && m_val[i] && m_ent[i] == cand) begin found = 1'b1; fi = i; end
        exp_hit  <= found;
        exp_hidx <= fi[3:0];
      end
      if (clear) begin
        m_val <= '0;
        wn    <= 0;
      end else if (load_valid) begin
        c = (wn == 0) ? int'(load_idx) : cap;
        cap <= c;
        wbuf[wn] <= load_word;
        if (wn == 3) begin
          if (c < E) begin
            m_ent[c] <= {wbuf[0], wbuf[1], wbuf[2], load_word};
            m_val[c] <= 1'b1;
          end
          wn <= 0;
        end else begin
          wn <= wn + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model; reset forces zeros immediately.
  always @(negedge CLK) begin
    if (run) begin
      chk("load_ready", {127'd0, load_ready}, {127'd0, ~clear});
      if (reset) begin
        chk("rst_dataOut", dataOut, 128'd0);
        chk("rst_flags", {dataOut_valid, dataOut_idx, hit_valid, hit, hit_idx}, 128'd0);
      end else begin
        chk("dataOut", dataOut, exp_do);
        chk("dataOut_valid", {127'd0, dataOut_valid}, {127'd0, exp_dov});
        chk("dataOut_idx", {124'd0, dataOut_idx}, {124'd0, exp_doi});
        chk("hit_valid", {127'd0, hit_valid}, {127'd0, exp_hv});
        chk("hit", {127'd0, hit}, {127'd0, exp_hit});
        chk("hit_idx", {124'd0, hit_idx}, {124'd0, exp_hidx});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #3;
  endtask

  task automatic load4(input logic [3:0] idx, input logic [127:0] d);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_idx   = idx;
      load_word  = d[127-32*i -: 32];
      tick();
    end
    load_valid = 1'b0;
  endtask

  localparam logic [127:0] D1 = 128'hf1d3ff8443297732862df21dc4e57262;
  localparam logic [127:0] D2 = 128'h11111111222222223333333344444444;
  localparam logic [127:0] D3 = 128'h0a0b0c0d1a1b1c1d2a2b2c2d3a3b3c3d;

  logic [3:0]   seq [40];
  logic [127:0] dv;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    run = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("reset_dataOut", dataOut, 128'd0);
    chk("reset_hit_valid", {127'd0, hit_valid}, 128'd0);
    chk("reset_load_ready", {127'd0, load_ready}, 128'd1);

    // Load and manual read.
    load4(4'd3, D1);
    selector = 4'd3;
    tick();
    chk("rd3_data", dataOut, 128'hf1d3ff8443297732862df21dc4e57262);
    chk("rd3_valid", {127'd0, dataOut_valid}, 128'd1);
    chk("rd3_idx", {124'd0, dataOut_idx}, 128'd3);

    // Match, hold, duplicates, miss.
    cand = D1; cand_valid = 1'b1;
    tick();
    chk("m1", {125'd0, hit_valid, hit, 1'b0}, {125'd0, 3'b110});
    chk("m1_idx", {124'd0, hit_idx}, 128'd3);
    cand_valid = 1'b0;
    tick();
    chk("m1_hold", {126'd0, hit_valid, hit}, 128'd1);
    load4(4'd9, D1);
    cand_valid = 1'b1;
    tick();
    chk("dup_idx", {124'd0, hit_idx}, 128'd3);
    cand = 128'd0;
    tick();
    chk("miss", {123'd0, hit, hit_idx}, 128'd0);
    cand_valid = 1'b0;

    // Clear in the middle of a digest.
    load_valid = 1'b1; load_idx = 4'd7;
    load_word = 32'hdeadbeef; tick();
    load_word = 32'hcafef00d; tick();
    clear = 1'b1; load_word = 32'h55555555;
    #1;
    chk("clr_ready", {127'd0, load_ready}, 128'd0);
    tick();
    clear = 1'b0; load_valid = 1'b0;
    selector = 4'd9;
    load4(4'd7, D2);
    selector = 4'd7;
    tick();
    chk("clr_fresh", dataOut, 128'h11111111222222223333333344444444);
    chk("clr_fresh_v", {127'd0, dataOut_valid}, 128'd1);
    selector = 4'd3;
    tick();
    chk("clr_inval", {127'd0, dataOut_valid}, 128'd0);
    chk("clr_keep", dataOut, D1);

    // Same-cycle commit versus read and compare.
    selector = 4'd5;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_idx = 4'd5; load_word = D3[127-32*i -: 32];
      tick();
    end
    load_word = D3[31:0]; cand = D3; cand_valid = 1'b1;
    tick();
    chk("cc_v0", {127'd0, dataOut_valid}, 128'd0);
    chk("cc_h0", {126'd0, hit_valid, hit}, 128'd2);
    load_valid = 1'b0;
    tick();
    chk("cc_v1", {127'd0, dataOut_valid}, 128'd1);
    chk("cc_h1", {123'd0, hit, hit_idx}, {123'd0, 1'b1, 4'd5});
    cand_valid = 1'b0;

    // Auto scan, dwell 2 then dwell 0.
    dwell = 24'd2; mode = 1'b1;
    for (int j = 0; j < 33; j++) begin tick(); seq[j] = dataOut_idx; end
    chk("sc2_0", {124'd0, seq[0]}, 128'd0);
    chk("sc2_1", {124'd0, seq[1]}, 128'd0);
    chk("sc2_2", {124'd0, seq[2]}, 128'd1);
    chk("sc2_31", {124'd0, seq[31]}, 128'd15);
    chk("sc2_32", {124'd0, seq[32]}, 128'd0);
    mode = 1'b0; tick();
    dwell = 24'd0; mode = 1'b1;
    for (int j = 0; j < 17; j++) begin tick(); seq[j] = dataOut_idx; end
    chk("sc0_0", {124'd0, seq[0]}, 128'd0);
    chk("sc0_1", {124'd0, seq[1]}, 128'd1);
    chk("sc0_15", {124'd0, seq[15]}, 128'd15);
    chk("sc0_16", {124'd0, seq[16]}, 128'd0);
    mode = 1'b0;

    // Reset in the middle of a digest.
    load_valid = 1'b1; load_idx = 4'd12;
    load_word = 32'h01234567; tick();
    load_word = 32'h89abcdef; tick();
    reset = 1'b1;
    #1;
    chk("rmid_data", dataOut, 128'd0);
    chk("rmid_flags", {dataOut_valid, hit}, 128'd0);
    load_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0; selector = 4'd12;
    tick();
    chk("rmid_v", {127'd0, dataOut_valid}, 128'd0);
    dv = 128'h0f0e0d0c0b0a09080706050403020100;
    load4(4'd12, dv);
    tick();
    chk("rmid_reload", dataOut, 128'h0f0e0d0c0b0a09080706050403020100);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
